cpu_multicycle: RTL and testbench
=================================

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter: MEM_TIMEOUT, 0, maximum wait cycles per memory request; 0 disables the timeout.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: n_reset  input  1  reset, asynchronous, active-low.
REQ-005 Port: memReq  output  1  memory request valid.
REQ-006 Port: memWe  output  1  request is a store (1) or a load/fetch (0).
REQ-007 Port: memAddr  output  32  byte address of the request.
REQ-008 Port: memWData  output  32  store data.
REQ-009 Port: memRData  input  32  load/fetch data; valid in the cycle memReady=1.
REQ-010 Port: memReady  input  1  memory accepts/completes the request this cycle.
REQ-011 Port: pc  output  32  address of the instruction currently executing.
REQ-012 Port: retire  output  1  one-cycle pulse when an instruction completes.
REQ-013 Port: halted  output  1  core stopped (illegal opcode or memory timeout).

Function
REQ-014 ISA subset: lw, sw, addi, add, sub, and, or, slt, beq, jal (RV32I encodings); every other opcode/funct combination is illegal.
REQ-015 Register file: 32 x 32-bit registers; x0 reads 0; writes to x0 are discarded.
REQ-016 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH: memReq=1, memWe=0, memAddr=pc; on memReady=1, latch memRData into the instruction register -> DECODE.
REQ-018 DECODE: read rs1/rs2, generate the sign-extended immediate (I/S/B/J formats) -> EXEC; an illegal opcode -> HALT.
REQ-019 EXEC, ALU/addi: write rd, pc<=pc+4, retire=1 -> FETCH.
REQ-020 EXEC, beq: pc<=(rs1==rs2) ? pc+immB : pc+4, retire=1 -> FETCH.
REQ-021 EXEC, jal: rd<=pc+4, pc<=pc+immJ, retire=1 -> FETCH.
REQ-022 EXEC, lw/sw: latch address rs1+imm (32-bit wrap, no overflow detection) -> MEM.
REQ-023 MEM: memReq=1, memAddr=latched address, memWe=1 for sw with memWData=rs2, memWe=0 for lw.
REQ-024 MEM, on memReady=1: sw -> pc<=pc+4, retire=1 -> FETCH; lw -> latch memRData -> WB.
REQ-025 WB: rd<=latched load data, pc<=pc+4, retire=1 -> FETCH.
REQ-026 Handshake: while memReq=1 and memReady=0, memAddr/memWe/memWData hold stable; transfer occurs only on a rising edge with memReq=1 and memReady=1.
REQ-027 memReady is ignored while memReq=0; memReq=0 in DECODE, EXEC, WB and HALT; memWe=0 whenever memReq=0.
REQ-028 Zero-wait latency: addi/ALU/beq/jal 3 cycles, sw 4 cycles, lw 5 cycles; each wait cycle on memReady adds one.
REQ-029 Timeout: with MEM_TIMEOUT=N>0, a request still unacknowledged after N consecutive wait cycles -> HALT, and no retire occurs.
REQ-030 HALT: halted=1, memReq=0, pc frozen; the core leaves HALT only through reset.
REQ-031 slt is a signed compare; lw/sw are word-only and ignore addr[1:0] (memAddr drives the full address unchanged).

Reset
REQ-032 n_reset=0 immediately forces: state=FETCH, pc=RESET_PC, all registers=0, memReq=0, memWe=0, memAddr=0, memWData=0, retire=0, halted=0.
REQ-033 Reset asserted mid-transaction abandons the transaction; the first cycle after release issues a FETCH at RESET_PC.

Verification
REQ-034 Reset, then program addi x1,x0,5; addi x2,x1,-7 with memReady tied to 1 -> x1=5, x2=0xFFFFFFFE, retire pulses at cycles 3 and 6, pc=8.
REQ-035 sw x2,4(x0) then lw x3,4(x0) with 2 wait cycles per request -> store to address 4 with data 0xFFFFFFFE holds stable through the waits; x3=0xFFFFFFFE.
REQ-036 beq x0,x0,-8 at pc=0x10 -> next fetch address 0x08; beq x1,x0,+8 with x1!=0 -> next fetch 0x14.
REQ-037 jal x0,+16 at pc=0x20 -> x0 stays 0, next fetch 0x30; jal x5,-4 at pc=0x30 -> x5=0x34, next fetch 0x2C.
REQ-038 Fetch returns 0xFFFFFFFF -> HALT after DECODE: halted=1, memReq=0, no retire pulse, pc unchanged.
REQ-039 MEM_TIMEOUT=4 with memReady held at 0 -> halted=1 after the 4th wait cycle; pulse n_reset low mid-wait -> FETCH at RESET_PC, halted=0.

Source files
------------

// File: rtl/cpu_multicycle.sv
`timescale 1ns/1ps
// cpu_multicycle
// Multi-cycle RV32I subset core: lw, sw, addi, add, sub, and, or, slt, beq, jal.
// A single shared memory port carries both instruction fetches and data accesses.
// Each instruction steps through FETCH -> DECODE -> EXEC [-> MEM [-> WB]].
// Any other encoding, or a memory request that waits too long, parks the core
// in HALT until reset.
//
// Ports
//   clk       rising-edge clock
//   n_reset   asynchronous active-low reset
//   memReq    memory request valid
//   memWe     1 = store, 0 = load/fetch
//   memAddr   byte address of the request
//   memWData  store data
//   memRData  load/fetch data, valid while memReady=1
//   memReady  request completes at the next rising edge
//   pc        address of the instruction currently executing
//   retire    one-cycle pulse when an instruction completes
//   halted    core stopped
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        n_reset,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t      stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] irReg;
  logic [31:0] rs1Reg, rs2Reg, immReg;
  logic [31:0] addrReg, loadReg;
  logic [31:0] waitCntReg;
  logic [31:0] regFile [32];

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = irReg[6:0];
  assign rd     = irReg[11:7];
  assign funct3 = irReg[14:12];
  assign rs1    = irReg[19:15];
  assign rs2    = irReg[24:20];
  assign funct7 = irReg[31:25];

  logic isLw, isSw, isAddi, isAlu, isBeq, isJal, isLegal;
  assign isLw   = (opcode == 7'h03) && (funct3 == 3'b010);
  assign isSw   = (opcode == 7'h23) && (funct3 == 3'b010);
  assign isAddi = (opcode == 7'h13) && (funct3 == 3'b000);
  assign isAlu  = (opcode == 7'h33) &&
                  (((funct7 == 7'h00) && ((funct3 == 3'b000) || (funct3 == 3'b111) ||
                                          (funct3 == 3'b110) || (funct3 == 3'b010))) ||
                   ((funct7 == 7'h20) && (funct3 == 3'b000)));
  assign isBeq  = (opcode == 7'h63) && (funct3 == 3'b000);
  assign isJal  = (opcode == 7'h6F);
  assign isLegal = isLw | isSw | isAddi | isAlu | isBeq | isJal;

  // Sign-extended immediates; the format is picked by instruction class
  logic [31:0] immI, immS, immB, immJ, immSel;
  assign immI = {{20{irReg[31]}}, irReg[31:20]};
  assign immS = {{20{irReg[31]}}, irReg[31:25], irReg[11:7]};
  assign immB = {{19{irReg[31]}}, irReg[31], irReg[7], irReg[30:25], irReg[11:8], 1'b0};
  assign immJ = {{11{irReg[31]}}, irReg[31], irReg[19:12], irReg[20], irReg[30:21], 1'b0};
  assign immSel = isSw ? immS : (isBeq ? immB : (isJal ? immJ : immI));

  // ALU: addi shares the add path with the immediate as second operand
  logic [31:0] aluB, aluRes;
  always_comb begin
    aluB   = isAddi ? immReg : rs2Reg;
    aluRes = rs1Reg + aluB;
    if (isAlu) begin
      case (funct3)
        3'b000:  aluRes = funct7[5] ? (rs1Reg - rs2Reg) : (rs1Reg + rs2Reg);
        3'b111:  aluRes = rs1Reg & rs2Reg;
        3'b110:  aluRes = rs1Reg | rs2Reg;
        3'b010:  aluRes = {31'b0, $signed(rs1Reg) < $signed(rs2Reg)};
        default: aluRes = rs1Reg + rs2Reg;
      endcase
    end
  end

  // Timeout fires on the Nth consecutive unacknowledged cycle of a request
  logic timedOut;
  assign timedOut = (MEM_TIMEOUT != 0) && !memReady &&
                    (waitCntReg == 32'(MEM_TIMEOUT - 1));

  // Next state, next pc and memory-port outputs
  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWData  = '0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (stateReg)
      FETCH: begin
        memReq  = 1'b1;
        memAddr = pcReg;
        if (memReady)      stateNext = DECODE;
        else if (timedOut) stateNext = HALT;
      end
      DECODE: stateNext = isLegal ? EXEC : HALT;
      EXEC: begin
        if (isLw || isSw) begin
          stateNext = MEM;
        end else begin
          retire    = 1'b1;
          stateNext = FETCH;
          if (isJal || (isBeq && (rs1Reg == rs2Reg))) pcNext = pcReg + immReg;
          else                                        pcNext = pcReg + 32'd4;
        end
      end
      MEM: begin
        memReq   = 1'b1;
        memAddr  = addrReg;
        memWe    = isSw;
        memWData = isSw ? rs2Reg : '0;
        if (memReady) begin
          if (isSw) begin
            retire    = 1'b1;
            pcNext    = pcReg + 32'd4;
            stateNext = FETCH;
          end else begin
            stateNext = WB;
          end
        end else if (timedOut) begin
          stateNext = HALT;
        end
      end
      WB: begin
        retire    = 1'b1;
        pcNext    = pcReg + 32'd4;
        stateNext = FETCH;
      end
      HALT:    halted = 1'b1;
      default: stateNext = HALT;
    endcase
    // The state register sits in FETCH while reset is held; keep the port quiet
    // until reset is released.
    if (!n_reset) begin
      memReq   = 1'b0;
      memWe    = 1'b0;
      memAddr  = '0;
      memWData = '0;
      retire   = 1'b0;
      halted   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stateReg   <= FETCH;
      pcReg      <= RESET_PC;
      irReg      <= '0;
      rs1Reg     <= '0;
      rs2Reg     <= '0;
      immReg     <= '0;
      addrReg    <= '0;
      loadReg    <= '0;
      waitCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      if ((stateReg == FETCH) && memReady) irReg <= memRData;
      if (stateReg == DECODE) begin
        rs1Reg <= regFile[rs1];
        rs2Reg <= regFile[rs2];
        immReg <= immSel;
      end
      if (stateReg == EXEC) addrReg <= rs1Reg + immReg;
      if ((stateReg == MEM) && memReady) loadReg <= memRData;
      waitCntReg <= (memReq && !memReady) ? waitCntReg + 32'd1 : 32'd0;
    end
  end

  // Register file; x0 is never written so it always reads 0
  logic        regWe;
  logic [31:0] regWData;
  always_comb begin
    regWe    = 1'b0;
    regWData = aluRes;
    if ((stateReg == EXEC) && (isAddi || isAlu)) regWe = 1'b1;
    if ((stateReg == EXEC) && isJal) begin
      regWe    = 1'b1;
      regWData = pcReg + 32'd4;
    end
    if (stateReg == WB) begin
      regWe    = 1'b1;
      regWData = loadReg;
    end
    if (rd == 5'd0) regWe = 1'b0;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (regWe) begin
      regFile[rd] <= regWData;
    end
  end

  assign pc = pcReg;

endmodule

// File: tb/tb_cpu_multicycle.sv
`timescale 1ns/1ps
// Testbench for cpu_multicycle: small directed programs run against a word
// memory model with a configurable number of wait cycles per request. Expected
// memory transfers and retire events are queued by the stimulus; a monitor on
// the falling edge pops and compares them.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        memReq, memWe, memReady, retire, halted;
  logic [31:0] memAddr, memWData, memRData, pc;

  cpu_multicycle #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memReady(memReady),
    .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
  typedef struct { int cyc; logic [31:0] pc; } ret_t;

  xfer_t       xferQ[$];
  ret_t        retQ[$];
  logic [31:0] mem [256];
  int          waitCycles = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          expCyc = 0;
  int          cycle = 0;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] ADDI(int rd, int rs1, int imm);
    logic [31:0] i = imm;
    return {i[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] LW(int rd, int rs1, int imm);
    logic [31:0] i = imm;
    return {i[11:0], 5'(rs1), 3'b010, 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] SW(int rs2, int rs1, int imm);
    logic [31:0] i = imm;
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] RTYPE(int f7, int f3, int rd, int rs1, int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] BEQ(int rs1, int rs2, int imm);
    logic [31:0] i = imm;
    return {i[12], i[10:5], 5'(rs2), 5'(rs1), 3'b000, i[4:1], i[11], 7'h63};
  endfunction
  function automatic logic [31:0] JAL(int rd, int imm);
    logic [31:0] i = imm;
    return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'h6F};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    expCyc = 0;
  endtask

  task automatic expFetch(input logic [31:0] a);
    xferQ.push_back('{1'b0, a, 32'h0});
  endtask
  task automatic expLoad(input logic [31:0] a);
    xferQ.push_back('{1'b0, a, 32'h0});
  endtask
  task automatic expStore(input logic [31:0] a, input logic [31:0] d);
    xferQ.push_back('{1'b1, a, d});
  endtask
  // nCyc = zero-wait latency, nReq = memory requests made by the instruction
  task automatic expRet(input logic [31:0] p, input int nCyc, input int nReq);
    expCyc += nCyc + nReq * waitCycles;
    retQ.push_back('{expCyc, p});
  endtask

  task automatic assertReset(input string tag);
    @(posedge clk); #3;
    n_reset = 1'b0;
    #1;
    chk({tag, "_rst_memReq"},   {31'b0, memReq},   32'h0);
    chk({tag, "_rst_memWe"},    {31'b0, memWe},    32'h0);
    chk({tag, "_rst_memAddr"},  memAddr,           32'h0);
    chk({tag, "_rst_memWData"}, memWData,          32'h0);
    chk({tag, "_rst_retire"},   {31'b0, retire},   32'h0);
    chk({tag, "_rst_halted"},   {31'b0, halted},   32'h0);
    chk({tag, "_rst_pc"},       pc,                32'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic releaseReset();
    #1 n_reset = 1'b1;
  endtask

  task automatic runToHalt(input string tag, input logic [31:0] haltPc);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, "_halted"}, {31'b0, halted}, 32'h1);
    chk({tag, "_halt_pc"}, pc, haltPc);
    chk({tag, "_halt_memReq"}, {31'b0, memReq}, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_pc_frozen"}, pc, haltPc);
    chk({tag, "_pending_xfers"}, 32'(xferQ.size()), 32'h0);
    chk({tag, "_pending_retires"}, 32'(retQ.size()), 32'h0);
    xferQ.delete();
    retQ.delete();
  endtask

  // ---------------- memory responder ----------------
  logic        inReq = 1'b0, capWe = 1'b0;
  logic [31:0] capAddr = '0, capData = '0;
  int          waitLeft = 0;
  initial begin
    memReady = 1'b0;
    memRData = '0;
    forever begin
      @(posedge clk); #2;
      if (!n_reset) begin
        memReady = 1'b0;
        inReq    = 1'b0;
      end else begin
        if (memReady) begin
          if (capWe) mem[capAddr[9:2]] = capData;
          inReq = 1'b0;
        end
        memReady = 1'b0;
        if (memReq) begin
          if (!inReq) begin
            inReq    = 1'b1;
            waitLeft = waitCycles;
          end
          if (waitLeft == 0) begin
            memReady = 1'b1;
            memRData = mem[memAddr[9:2]];
            capWe    = memWe;
            capAddr  = memAddr;
            capData  = memWData;
          end else begin
            waitLeft--;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prevWait = 1'b0, prevWe = 1'b0;
  logic [31:0] prevAddr = '0, prevData = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        cycle    = 0;
        prevWait = 1'b0;
      end else begin
        cycle++;
        if (prevWait && memReq) begin
          vectors++;
          if (memAddr !== prevAddr || memWe !== prevWe || memWData !== prevData) begin
            miscompares++;
            $display("FAIL hold_stable cyc=%0d: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                     cycle, memWe, memAddr, memWData, prevWe, prevAddr, prevData);
          end
        end
        if (memReq && memReady) begin
          vectors++;
          if (xferQ.size() == 0) begin
            miscompares++;
            $display("FAIL xfer_unexpected cyc=%0d: got we=%0b addr=%h data=%h expected none",
                     cycle, memWe, memAddr, memWData);
          end else begin
            xfer_t e;
            e = xferQ.pop_front();
            if (memWe !== e.we || memAddr !== e.addr || (e.we && memWData !== e.data)) begin
              miscompares++;
              $display("FAIL xfer cyc=%0d: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                       cycle, memWe, memAddr, memWData, e.we, e.addr, e.data);
            end else begin
              $display("xfer ok   cyc=%0d we=%0b addr=%h data=%h", cycle, memWe, memAddr, memWData);
            end
          end
        end
        if (retire) begin
          vectors++;
          if (retQ.size() == 0) begin
            miscompares++;
            $display("FAIL retire_unexpected cyc=%0d: got pc=%h expected none", cycle, pc);
          end else begin
            ret_t r;
            r = retQ.pop_front();
            if (cycle != r.cyc || pc !== r.pc) begin
              miscompares++;
              $display("FAIL retire: got cyc=%0d pc=%h expected cyc=%0d pc=%h", cycle, pc, r.cyc, r.pc);
            end else begin
              $display("retire ok cyc=%0d pc=%h", cycle, pc);
            end
          end
        end
        prevWait = memReq && !memReady;
        prevWe   = memWe;
        prevAddr = memAddr;
        prevData = memWData;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Program 1: addi chain, zero wait, ends on an all-ones word
    clearMem();
    waitCycles = 0;
    put(32'h00, ADDI(1, 0, 5));
    put(32'h04, ADDI(2, 1, -7));
    put(32'h08, SW(1, 0, 32'h40));
    put(32'h0C, SW(2, 0, 32'h44));
    put(32'h10, 32'hFFFF_FFFF);
    expFetch(32'h00); expRet(32'h00, 3, 1);
    expFetch(32'h04); expRet(32'h04, 3, 1);
    expFetch(32'h08); expStore(32'h40, 32'h0000_0005);      expRet(32'h08, 4, 2);
    expFetch(32'h0C); expStore(32'h44, 32'hFFFF_FFFE);      expRet(32'h0C, 4, 2);
    expFetch(32'h10);
    assertReset("p1");
    releaseReset();
    runToHalt("p1", 32'h10);

    // Program 2: store then load back with two wait cycles per request
    clearMem();
    waitCycles = 2;
    put(32'h00, ADDI(2, 0, -2));
    put(32'h04, SW(2, 0, 4));
    put(32'h08, LW(3, 0, 4));
    put(32'h0C, SW(3, 0, 32'h48));
    put(32'h10, 32'hFFFF_FFFF);
    expFetch(32'h00); expRet(32'h00, 3, 1);
    expFetch(32'h04); expStore(32'h04, 32'hFFFF_FFFE);      expRet(32'h04, 4, 2);
    expFetch(32'h08); expLoad(32'h04);                      expRet(32'h08, 5, 2);
    expFetch(32'h0C); expStore(32'h48, 32'hFFFF_FFFE);      expRet(32'h0C, 4, 2);
    expFetch(32'h10);
    assertReset("p2");
    releaseReset();
    runToHalt("p2", 32'h10);

    // Program 3: branches and jumps, zero wait
    clearMem();
    waitCycles = 0;
    put(32'h00, ADDI(1, 0, 5));
    put(32'h04, JAL(0, 12));
    put(32'h08, JAL(0, 20));
    put(32'h0C, 32'hFFFF_FFFF);
    put(32'h10, BEQ(0, 0, -8));
    put(32'h1C, BEQ(1, 0, 8));
    put(32'h20, JAL(0, 16));
    put(32'h2C, BEQ(0, 0, 20));
    put(32'h30, JAL(5, -4));
    put(32'h40, SW(5, 0, 32'h60));
    put(32'h44, SW(0, 0, 32'h64));
    put(32'h48, 32'hFFFF_FFFF);
    expFetch(32'h00); expRet(32'h00, 3, 1);
    expFetch(32'h04); expRet(32'h04, 3, 1);
    expFetch(32'h10); expRet(32'h10, 3, 1);
    expFetch(32'h08); expRet(32'h08, 3, 1);
    expFetch(32'h1C); expRet(32'h1C, 3, 1);
    expFetch(32'h20); expRet(32'h20, 3, 1);
    expFetch(32'h30); expRet(32'h30, 3, 1);
    expFetch(32'h2C); expRet(32'h2C, 3, 1);
    expFetch(32'h40); expStore(32'h60, 32'h0000_0034);      expRet(32'h40, 4, 2);
    expFetch(32'h44); expStore(32'h64, 32'h0000_0000);      expRet(32'h44, 4, 2);
    expFetch(32'h48);
    assertReset("p3");
    releaseReset();
    runToHalt("p3", 32'h48);

    // Program 4: ALU ops with one wait cycle, ends on an illegal R-type funct7
    clearMem();
    waitCycles = 1;
    put(32'h00, ADDI(1, 0, 5));
    put(32'h04, ADDI(2, 0, -2));
    put(32'h08, RTYPE(7'h00, 0, 3, 1, 2));   // add
    put(32'h0C, RTYPE(7'h20, 0, 4, 1, 2));   // sub
    put(32'h10, RTYPE(7'h00, 7, 5, 1, 2));   // and
    put(32'h14, RTYPE(7'h00, 6, 6, 1, 2));   // or
    put(32'h18, RTYPE(7'h00, 2, 7, 2, 1));   // slt -2 < 5
    put(32'h1C, RTYPE(7'h00, 2, 8, 1, 2));   // slt 5 < -2
    put(32'h20, ADDI(0, 1, 1));
    put(32'h24, SW(3, 0, 32'h80));
    put(32'h28, SW(4, 0, 32'h84));
    put(32'h2C, SW(5, 0, 32'h88));
    put(32'h30, SW(6, 0, 32'h8C));
    put(32'h34, SW(7, 0, 32'h90));
    put(32'h38, SW(8, 0, 32'h94));
    put(32'h3C, SW(0, 0, 32'h98));
    put(32'h40, RTYPE(7'h01, 0, 9, 1, 2));   // mul encoding: not supported
    for (int k = 0; k < 9; k++) begin
      expFetch(32'(4 * k));
      expRet(32'(4 * k), 3, 1);
    end
    expFetch(32'h24); expStore(32'h80, 32'h0000_0003); expRet(32'h24, 4, 2);
    expFetch(32'h28); expStore(32'h84, 32'h0000_0007); expRet(32'h28, 4, 2);
    expFetch(32'h2C); expStore(32'h88, 32'h0000_0004); expRet(32'h2C, 4, 2);
    expFetch(32'h30); expStore(32'h8C, 32'hFFFF_FFFF); expRet(32'h30, 4, 2);
    expFetch(32'h34); expStore(32'h90, 32'h0000_0001); expRet(32'h34, 4, 2);
    expFetch(32'h38); expStore(32'h94, 32'h0000_0000); expRet(32'h38, 4, 2);
    expFetch(32'h3C); expStore(32'h98, 32'h0000_0000); expRet(32'h3C, 4, 2);
    expFetch(32'h40);
    assertReset("p4");
    releaseReset();
    runToHalt("p4", 32'h40);

    // Timeout: fetch never acknowledged, limit of 4 wait cycles
    clearMem();
    waitCycles = 1000;
    put(32'h00, ADDI(1, 0, 9));
    assertReset("to");
    releaseReset();
    repeat (4) @(negedge clk);
    #1;
    chk("to_cyc4_halted", {31'b0, halted}, 32'h0);
    chk("to_cyc4_memReq", {31'b0, memReq}, 32'h1);
    @(negedge clk);
    #1;
    chk("to_cyc5_halted", {31'b0, halted}, 32'h1);
    chk("to_cyc5_memReq", {31'b0, memReq}, 32'h0);
    chk("to_cyc5_pc",     pc,              32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("to_still_halted", {31'b0, halted}, 32'h1);

    // Reset pulsed in the middle of a waiting fetch, then a normal run
    assertReset("mw_a");
    releaseReset();
    repeat (2) @(negedge clk);
    clearMem();
    put(32'h00, ADDI(1, 0, 9));
    put(32'h04, SW(1, 0, 32'h70));
    put(32'h08, 32'hFFFF_FFFF);
    assertReset("mw_b");
    waitCycles = 0;
    expFetch(32'h00); expRet(32'h00, 3, 1);
    expFetch(32'h04); expStore(32'h70, 32'h0000_0009); expRet(32'h04, 4, 2);
    expFetch(32'h08);
    releaseReset();
    @(negedge clk);
    #1;
    chk("mw_cyc1_memReq",  {31'b0, memReq}, 32'h1);
    chk("mw_cyc1_memAddr", memAddr,         32'h0);
    chk("mw_cyc1_halted",  {31'b0, halted}, 32'h0);
    runToHalt("mw", 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
